regfile_demux: RTL

REGFILE_DEMUX -- requirements
Module: regfile_demux

---
 rtl/regfile_demux.sv | 80 ++++++++
 1 files changed

// File: rtl/regfile_demux.sv
// Register file with a one-hot decoded write port and two combinational read ports; x0 is hard-wired to zero.
// Optional macro REGFILE_BYPASS_EN forwards wd3 to a read port addressing the register being written.
module regfile_demux #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we3,
    input  logic [AW-1:0]   a3,
    input  logic [XLEN-1:0] wd3,
    input  logic [AW-1:0]   a1,
    input  logic [AW-1:0]   a2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:1] wen;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_store
                logic [XLEN-1:0] q_reg;

                // One-hot decode: a3 = 0 never matches, so writes to x0 vanish here.
                assign wen[gi] = we3 && (a3 == AW'(gi));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (wen[gi]) begin
                        q_reg <= wd3;
                    end
                end

                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    logic a1_ok, a2_ok;
    assign a1_ok = rst_n && (a1 != '0) && ({1'b0, a1} < (AW+1)'(NREGS));
    assign a2_ok = rst_n && (a2 != '0) && ({1'b0, a2} < (AW+1)'(NREGS));

`ifdef REGFILE_BYPASS_EN
    logic wr_any;
    assign wr_any = |wen;
`endif

    always_comb begin
        rd1 = '0;
        if (a1_ok) begin
            rd1 = regs[a1];
        end
`ifdef REGFILE_BYPASS_EN
        // wr_any already excludes x0 and out-of-range targets; reset masks the forward path.
        if (rst_n && wr_any && (a3 == a1)) begin
            rd1 = wd3;
        end
`endif
    end

    always_comb begin
        rd2 = '0;
        if (a2_ok) begin
            rd2 = regs[a2];
        end
`ifdef REGFILE_BYPASS_EN
        if (rst_n && wr_any && (a3 == a2)) begin
            rd2 = wd3;
        end
`endif
    end

endmodule
